// File: rtl/divide_result_checker.sv
// Rebuilds the dividend from a divider result as quotient*divisor + remainder, using a
// bit-serial shift-add multiplier, and flags whether the result is consistent.
module divide_result_checker #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   remainder,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   expected_dividend,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] reconstructed,
    output logic               match,
    output logic               rem_err,
    output logic               overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StMult, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               valid_q, valid_d;
    logic [2*WIDTH-1:0] recon_q, recon_d;
    logic               match_q, match_d;
    logic               rem_err_q, rem_err_d;
    logic               overflow_q, overflow_d;

    logic [2*WIDTH-1:0] div_shifted;
    logic [2*WIDTH-1:0] recon_sum;
    logic               rem_bad;

    // Product of two WIDTH-bit values plus a WIDTH-bit value always fits in 2*WIDTH bits.
    assign div_shifted = {{WIDTH{1'b0}}, div_q} << count_q;
    assign recon_sum   = acc_q + {{WIDTH{1'b0}}, rem_q};
    assign rem_bad     = (div_q != '0) && (rem_q >= div_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_d      = div_q;
        dvd_d      = dvd_q;
        acc_d      = acc_q;
        valid_d    = 1'b0;
        recon_d    = recon_q;
        match_d    = match_q;
        rem_err_d  = rem_err_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    quot_d  = quotient;
                    rem_d   = remainder;
                    div_d   = divisor;
                    dvd_d   = expected_dividend;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StMult;
                end
            end
            StMult: begin
                if (quot_q[count_q]) begin
                    acc_d = acc_q + div_shifted;
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                recon_d    = recon_sum;
                rem_err_d  = rem_bad;
                overflow_d = |recon_sum[2*WIDTH-1:WIDTH];
                match_d    = (recon_sum == {{WIDTH{1'b0}}, dvd_q}) && !rem_bad;
                valid_d    = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            dvd_q      <= '0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            recon_q    <= '0;
            match_q    <= 1'b0;
            rem_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            dvd_q      <= dvd_d;
            acc_q      <= acc_d;
            valid_q    <= valid_d;
            recon_q    <= recon_d;
            match_q    <= match_d;
            rem_err_q  <= rem_err_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign valid         = valid_q;
    assign reconstructed = recon_q;
    assign match         = match_q;
    assign rem_err       = rem_err_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_divide_result_checker.sv
// Directed bench for divide_result_checker: hand-computed reconstruction vectors, latency,
// back-to-back starts, ignored start while busy and mid-operation reset.
module tb_divide_result_checker;

    localparam int unsigned WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   quotient = '0;
    logic [WIDTH-1:0]   remainder = '0;
    logic [WIDTH-1:0]   divisor = '0;
    logic [WIDTH-1:0]   expected_dividend = '0;
    logic               busy;
    logic               valid;
    logic [2*WIDTH-1:0] reconstructed;
    logic               match;
    logic               rem_err;
    logic               overflow;

    int total = 0;
    int bad = 0;
    logic [2*WIDTH-1:0] prev_recon = '0;

    divide_result_checker #(.WIDTH(WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .quotient          (quotient),
        .remainder         (remainder),
        .divisor           (divisor),
        .expected_dividend (expected_dividend),
        .busy              (busy),
        .valid             (valid),
        .reconstructed     (reconstructed),
        .match             (match),
        .rem_err           (rem_err),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble inputs while busy, wait for valid and check results.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] dvd,
                          input logic [2*WIDTH-1:0] e_recon, input logic e_match,
                          input logic e_rem_err, input logic e_overflow, input bit gap);
        int n;
        quotient          = q;
        remainder         = r;
        divisor           = d;
        expected_dividend = dvd;
        start             = 1'b1;
        @(posedge clk);
        #1;
        start             = 1'b0;
        quotient          = ~q;
        remainder         = ~r;
        divisor           = ~d;
        expected_dividend = ~dvd;
        check({tag, ".busy"}, busy, 1);
        check({tag, ".hold"}, reconstructed, prev_recon);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = i;
                break;
            end
        end
        check({tag, ".latency"}, n, 17);
        check({tag, ".recon"}, reconstructed, e_recon);
        check({tag, ".match"}, match, e_match);
        check({tag, ".rem_err"}, rem_err, e_rem_err);
        check({tag, ".overflow"}, overflow, e_overflow);
        check({tag, ".busy_done"}, busy, 0);
        prev_recon = e_recon;
        if (gap) begin
            @(posedge clk);
            #1;
            check({tag, ".valid_pulse"}, valid, 0);
            check({tag, ".recon_kept"}, reconstructed, e_recon);
        end
    endtask

    initial begin
        int pulses;
        #1;
        check("rst.busy", busy, 0);
        check("rst.valid", valid, 0);
        check("rst.recon", reconstructed, 0);
        check("rst.match", match, 0);
        check("rst.rem_err", rem_err, 0);
        check("rst.overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 16'd14, 16'd2, 16'd7, 16'd100, 32'h0000_0064, 1, 0, 0, 1);
        run_op("div0", 16'd0, 16'h1234, 16'd0, 16'h1234, 32'h0000_1234, 1, 0, 0, 1);
        run_op("badq", 16'd15, 16'd2, 16'd7, 16'd100, 32'h0000_006B, 0, 0, 0, 1);
        run_op("badr", 16'd13, 16'd9, 16'd7, 16'd100, 32'h0000_0064, 0, 1, 0, 1);
        run_op("ovf", 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE, 32'hFFFE_FFFF, 0, 0, 1, 1);
        run_op("req", 16'd0, 16'd5, 16'd5, 16'd5, 32'h0000_0005, 0, 1, 0, 1);
        run_op("div0bad", 16'd0, 16'd5, 16'd0, 16'd6, 32'h0000_0005, 0, 0, 0, 1);
        // Back-to-back: second start lands in the cycle valid is high.
        run_op("b2b_a", 16'd3, 16'd1, 16'd10, 16'd31, 32'h0000_001F, 1, 0, 0, 0);
        run_op("b2b_b", 16'h0100, 16'h00FF, 16'h0100, 16'hFFFF, 32'h0001_00FF, 0, 0, 1, 1);

        // Start while busy must be ignored; reset mid-operation must abort with no valid.
        quotient          = 16'd14;
        remainder         = 16'd2;
        divisor           = 16'd7;
        expected_dividend = 16'd100;
        start             = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        quotient = 16'd3;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort.busy", busy, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort.busy_rst", busy, 0);
        check("abort.valid_rst", valid, 0);
        check("abort.recon_rst", reconstructed, 0);
        check("abort.match_rst", match, 0);
        check("abort.overflow_rst", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (valid || busy) pulses++;
        end
        check("abort.no_activity", pulses, 0);
        prev_recon = '0;
        run_op("after_rst", 16'd14, 16'd2, 16'd7, 16'd100, 32'h0000_0064, 1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
